// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch unit with prefetch buffer and redirect handling
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  output logic [31:0] instruction,
  output logic [31:0] instrPC,
  input  logic        instrReady,
  output logic        fetchFault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]       state;
  logic [31:0]      fetchPC;
  logic             discard;
  logic [31:0]      dataMem [FIFO_DEPTH];
  logic [31:0]      pcMem   [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;

  logic pop;
  logic push;
  logic bufFull;
  logic canIssue;
  logic redirectAligned;
  logic dropNext;

  // Buffer head is presented combinationally; zeroed when nothing is buffered.
  assign instrValid  = (count != '0);
  assign instruction = instrValid ? dataMem[rdPtr] : 32'h0;
  assign instrPC     = instrValid ? pcMem[rdPtr] : 32'h0;
  assign pop         = instrValid && instrReady;
  assign bufFull     = (count == DEPTH_CNT);

  // A request only goes out when the slot it reserves is guaranteed free on
  // return: during WAIT the buffer can only drain, so a response always fits.
  assign canIssue = (state == FETCH) && !discard && (!bufFull || pop);
  assign imemReq  = rstN && canIssue;
  assign imemAddr = imemReq ? fetchPC : 32'h0;

  assign redirectAligned = redirectValid && (redirectTarget[1:0] == 2'b00);
  assign push            = (state == WAIT) && imemValid && !discard && !redirectValid;

  // On a redirect, a response still owed by memory must be thrown away: either
  // one requested this cycle, one still awaited in WAIT, or an earlier stale one.
  assign dropNext = imemReq || ((state == WAIT) && !imemValid) || (discard && !imemValid);

  // Control FSM, fetch PC, discard flag and sticky fault flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= FETCH;
      fetchPC    <= RESET_PC;
      discard    <= 1'b0;
      fetchFault <= 1'b0;
    end else if (redirectValid) begin
      discard <= dropNext;
      if (redirectAligned) begin
        state   <= FETCH;
        fetchPC <= redirectTarget;
      end else begin
        state      <= FAULT;
        fetchFault <= 1'b1;
      end
    end else begin
      if (discard && imemValid) begin
        discard <= 1'b0;
      end
      case (state)
        FETCH: begin
          if (canIssue) begin
            state <= WAIT;
          end else if (!discard) begin
            state <= STALL;
          end
        end
        WAIT: begin
          if (imemValid) begin
            fetchPC <= fetchPC + 32'd4;
            state   <= FETCH;
          end
        end
        STALL: begin
          if (pop) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (redirectValid) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr] <= imemData;
      pcMem[wrPtr]   <= fetchPC;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemReq, imemReq1;
  logic [31:0] imemAddr, imemAddr1;
  logic        imemValid;
  logic [31:0] imemData;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        instrValid, instrValid1;
  logic [31:0] instruction, instruction1;
  logic [31:0] instrPC, instrPC1;
  logic        instrReady;
  logic        fetchFault, fetchFault1;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rstN(rstN), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData), .redirectValid(redirectValid),
    .redirectTarget(redirectTarget), .instrValid(instrValid), .instruction(instruction),
    .instrPC(instrPC), .instrReady(instrReady), .fetchFault(fetchFault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutWrap (
    .clk(clk), .rstN(rstN), .imemReq(imemReq1), .imemAddr(imemAddr1),
    .imemValid(imemValid), .imemData(imemData), .redirectValid(redirectValid),
    .redirectTarget(redirectTarget), .instrValid(instrValid1), .instruction(instruction1),
    .instrPC(instrPC1), .instrReady(instrReady), .fetchFault(fetchFault1)
  );

  int tests = 0;
  int fails = 0;
  int handshakes = 0;

  logic [31:0] expQ[$];
  logic [31:0] expQ1[$];
  bit faultExp  = 1'b0;
  bit faultMode = 1'b0;

  int          memLatMin = 1;
  int          memLatMax = 1;
  bit          memPending = 1'b0;
  int          memWait = 0;
  logic [31:0] memAddrQ = 32'h0;
  bit          staleInject = 1'b0;
  bit          strayEnable = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Program order from a start PC: consecutive words, wrapping at 2^32.
  task automatic startStream(input logic [31:0] pc);
    logic [31:0] p;
    expQ.delete();
    p = pc;
    for (int i = 0; i < 1024; i++) begin
      expQ.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic applyRedirectModel(input logic [31:0] t);
    expQ1.delete();
    if (t[1:0] == 2'b00) begin
      startStream(t);
      faultMode = 1'b0;
    end else begin
      expQ.delete();
      faultExp  = 1'b1;
      faultMode = 1'b1;
    end
  endtask

  task automatic redirectOnce(input logic [31:0] t);
    @(posedge clk); #1;
    redirectValid  = 1'b1;
    redirectTarget = t;
    @(posedge clk); #1;
    redirectValid = 1'b0;
    applyRedirectModel(t);
  endtask

  task automatic waitReq(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (imemReq) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: no imemReq within 60 cycles, expected one", name);
    end
  endtask

  task automatic doReset(input int hold, input bit stale);
    @(posedge clk); #1;
    rstN          = 1'b0;
    redirectValid = 1'b0;
    faultExp      = 1'b0;
    faultMode     = 1'b0;
    startStream(32'h0);
    expQ1 = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    #2;
    check("reset imemReq", imemReq, 0);
    check("reset imemAddr", imemAddr, 0);
    check("reset instrValid", instrValid, 0);
    check("reset instruction", instruction, 0);
    check("reset instrPC", instrPC, 0);
    check("reset fetchFault", fetchFault, 0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    staleInject = stale;
    @(posedge clk); #2;
    rstN = 1'b1;
    #1;
    check("first imemReq", imemReq, 1);
    check("first imemAddr", imemAddr, 32'h0);
    check("first imemAddr wrap", imemAddr1, 32'hFFFF_FFF8);
  endtask

  // Memory model: responds to each request after a chosen latency.
  initial begin
    imemValid = 1'b0;
    imemData  = 32'h0;
    forever begin
      @(posedge clk); #1;
      imemValid = 1'b0;
      imemData  = 32'h0;
      if (staleInject) begin
        imemValid   = 1'b1;
        imemData    = 32'hDEAD_BEEF;
        staleInject = 1'b0;
      end else if (!rstN) begin
        memPending = 1'b0;
      end else if (memPending) begin
        if (memWait <= 1) begin
          imemValid  = 1'b1;
          imemData   = memWord(memAddrQ);
          memPending = 1'b0;
        end else begin
          memWait--;
        end
      end else if (strayEnable && $urandom_range(0, 15) == 0) begin
        imemValid = 1'b1;
        imemData  = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
      @(negedge clk);
      if (rstN && imemReq) begin
        check("single outstanding", {31'b0, memPending}, 0);
        memPending = 1'b1;
        memAddrQ   = imemAddr;
        memWait    = $urandom_range(memLatMin, memLatMax);
      end
    end
  end

  // Monitor: compares every delivered instruction against the scoreboard.
  initial begin
    logic [31:0] e;
    bit          haveE;
    forever begin
      @(negedge clk);
      if (rstN === 1'b1) begin
        check("fetchFault", fetchFault, faultExp);
        check("fetchFault wrap", fetchFault1, faultExp);
        if (faultMode) begin
          check("no imemReq in fault", imemReq, 0);
          check("no imemReq in fault wrap", imemReq1, 0);
        end
        haveE = 1'b0;
        if (instrValid && instrReady) begin
          handshakes++;
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected instr: got pc %h, expected none", instrPC);
          end else begin
            e = expQ.pop_front();
            haveE = 1'b1;
            check("instrPC", instrPC, e);
            check("instruction", instruction, memWord(e));
          end
        end
        if (instrValid1 && instrReady && expQ1.size() > 0) begin
          check("instrPC wrap", instrPC1, expQ1.pop_front());
          if (haveE) check("instruction wrap", instruction1, memWord(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  reqCount;
    int  h0;
    bit  seen;
    logic [31:0] t;
    rstN           = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = 32'h0;
    instrReady     = 1'b1;

    // Latency 1, decoder always ready: one instruction every 2 cycles.
    memLatMin = 1; memLatMax = 1;
    doReset(2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("valid cadence c%0d", k), instrValid, (k >= 2 && k % 2 == 0) ? 1 : 0);
    end
    repeat (6) @(posedge clk);

    // Decoder stalled for 10 cycles: two entries buffered, no requests, head stable.
    instrReady = 1'b0;
    doReset(2, 1'b0);
    reqCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imemReq) reqCount++;
      if (k >= 5) begin
        check("stall head valid", instrValid, 1);
        check("stall head pc", instrPC, 32'h0);
        check("stall head data", instruction, memWord(32'h0));
      end
    end
    check("stall request count", reqCount, 2);
    @(posedge clk); #1;
    instrReady = 1'b1;
    @(negedge clk);
    check("drain valid 0", instrValid, 1);
    @(negedge clk);
    check("drain valid 1", instrValid, 1);
    repeat (8) @(posedge clk);

    // Latency 3, redirect while the 0x8 fetch is outstanding.
    memLatMin = 3; memLatMax = 3;
    doReset(2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (imemReq && imemAddr == 32'h8) seen = 1'b1;
    end
    check("saw request 0x8", {31'b0, seen}, 1);
    h0 = handshakes;
    redirectOnce(32'h100);
    waitReq("request after redirect", seen);
    if (seen) check("redirect imemAddr", imemAddr, 32'h100);
    repeat (20) @(posedge clk);
    check("progress after redirect", {31'b0, handshakes > h0}, 1);

    // Misaligned redirect faults; aligned redirect recovers fetch, fault stays set.
    memLatMin = 1; memLatMax = 1;
    redirectOnce(32'h102);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("fault instrValid", instrValid, 0);
    end
    redirectOnce(32'h200);
    waitReq("request after fault", seen);
    if (seen) check("fault exit imemAddr", imemAddr, 32'h200);
    check("fault sticky", fetchFault, 1);
    repeat (10) @(posedge clk);

    // Reset during WAIT followed by a stale response before the new request completes.
    memLatMin = 3; memLatMax = 3;
    doReset(2, 1'b0);
    memLatMin = 1; memLatMax = 1;
    h0 = handshakes;
    doReset(2, 1'b1);
    repeat (8) @(posedge clk);
    check("progress after stale", {31'b0, handshakes > h0}, 1);

    // Randomized traffic: random latency, backpressure, redirects and stray strobes.
    memLatMin = 1; memLatMax = 4;
    doReset(2, 1'b0);
    strayEnable = 1'b1;
    h0 = handshakes;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (redirectValid) begin
        redirectValid = 1'b0;
        applyRedirectModel(redirectTarget);
      end
      instrReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, faultMode ? 7 : 39) == 0) begin
        t = $urandom & 32'h0000_FFFC;
        if (!faultMode && $urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        redirectValid  = 1'b1;
        redirectTarget = t;
      end
    end
    @(posedge clk); #1;
    if (redirectValid) begin
      redirectValid = 1'b0;
      applyRedirectModel(redirectTarget);
    end
    strayEnable = 1'b0;
    repeat (10) @(posedge clk);
    check("random progress", {31'b0, (handshakes - h0) > 100}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
